// File: rtl/execute_sequencer_if.sv
// Fetch/datapath-facing bundle of the execute sequencer: instruction handshake,
// decoder flags, multiplier handshake, datapath controls, retire/error status.
interface execute_sequencer_if #(
  parameter int unsigned IMM_WIDTH = 8,
  parameter int unsigned RET_WIDTH = 16
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 f_add;
  logic                 f_imm;
  logic                 f_wait;
  logic                 f_load;
  logic                 f_wr_res;
  logic [IMM_WIDTH-1:0] imm;
  logic                 mul_start;
  logic                 mul_done;
  logic                 alu_add;
  logic                 op_b_imm;
  logic                 wb_load;
  logic                 reg_we;
  logic                 pc_en;
  logic [RET_WIDTH-1:0] retire_cnt;
  logic                 err_illegal;
  logic                 err_mul_to;
  logic                 err_clr;

  // Fetch / datapath side
  modport master (
    output instr_valid, f_add, f_imm, f_wait, f_load, f_wr_res, imm,
           mul_done, err_clr,
    input  instr_ready, mul_start, alu_add, op_b_imm, wb_load, reg_we,
           pc_en, retire_cnt, err_illegal, err_mul_to
  );

  // Sequencer side
  modport slave (
    input  instr_valid, f_add, f_imm, f_wait, f_load, f_wr_res, imm,
           mul_done, err_clr,
    output instr_ready, mul_start, alu_add, op_b_imm, wb_load, reg_we,
           pc_en, retire_cnt, err_illegal, err_mul_to
  );
endinterface

// File: rtl/execute_sequencer.sv
// Multi-cycle execute controller: accepts one decoded instruction at a time and
// steps it through ALU writeback, handshaked multiply, WAIT stall or retire.
module execute_sequencer #(
  parameter int unsigned IMM_WIDTH   = 8,
  parameter int unsigned MUL_TIMEOUT = 16,
  parameter int unsigned RET_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  execute_sequencer_if.slave bus
);

  localparam int unsigned TMR_WIDTH = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_WAIT,
    S_WB,
    S_RETIRE
  } state_e;

  state_e               state_q, state_d;
  logic [IMM_WIDTH-1:0] cnt_q, cnt_d;
  logic [TMR_WIDTH-1:0] tmr_q, tmr_d;
  logic                 wr_res_q, wr_res_d;
  logic                 alu_add_q, alu_add_d;
  logic                 op_b_imm_q, op_b_imm_d;
  logic                 wb_load_q, wb_load_d;
  logic                 mul_start_q, mul_start_d;
  logic                 reg_we_q, reg_we_d;
  logic                 pc_en_q, pc_en_d;
  logic [RET_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  logic                 err_illegal_q, err_illegal_d;
  logic                 err_mul_to_q, err_mul_to_d;
  logic                 accept_c;
  logic                 ill_set_c;
  logic                 mto_set_c;

  assign bus.instr_ready = (state_q == S_IDLE);
  assign accept_c        = bus.instr_valid & (state_q == S_IDLE);

  // Next state, latched flags and registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    wr_res_d     = wr_res_q;
    alu_add_d    = alu_add_q;
    op_b_imm_d   = op_b_imm_q;
    wb_load_d    = wb_load_q;
    mul_start_d  = 1'b0;
    ill_set_c    = 1'b0;
    mto_set_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          alu_add_d  = bus.f_add;
          op_b_imm_d = bus.f_imm;
          wb_load_d  = bus.f_load;
          wr_res_d   = bus.f_wr_res;
          if (bus.f_wait) begin
            if (bus.imm == '0) begin
              state_d = S_RETIRE;
            end else begin
              state_d = S_WAIT;
              cnt_d   = bus.imm;
            end
          end else if (bus.f_load || bus.f_add) begin
            state_d = S_WB;
          end else if (bus.f_wr_res) begin
            state_d     = S_MUL;
            tmr_d       = TMR_WIDTH'(1);
            mul_start_d = 1'b1;
          end else begin
            state_d   = S_RETIRE;
            ill_set_c = 1'b1;
          end
        end
      end
      S_MUL: begin
        // A done arriving in the timeout cycle still counts as success
        if (bus.mul_done) begin
          state_d = S_WB;
        end else if (tmr_q == TMR_WIDTH'(MUL_TIMEOUT)) begin
          state_d   = S_RETIRE;
          mto_set_c = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == IMM_WIDTH'(1)) begin
          state_d = S_RETIRE;
        end else begin
          cnt_d = cnt_q - IMM_WIDTH'(1);
        end
      end
      S_WB:     state_d = S_IDLE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Datapath selects read as zero whenever the sequencer sits in IDLE
    if (state_d == S_IDLE) begin
      alu_add_d  = 1'b0;
      op_b_imm_d = 1'b0;
      wb_load_d  = 1'b0;
      wr_res_d   = 1'b0;
    end

    reg_we_d      = (state_d == S_WB) & wr_res_d;
    pc_en_d       = (state_d == S_WB) || (state_d == S_RETIRE);
    retire_cnt_d  = retire_cnt_q + RET_WIDTH'(pc_en_q);
    err_illegal_d = ill_set_c | (err_illegal_q & ~bus.err_clr);
    err_mul_to_d  = mto_set_c | (err_mul_to_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      wr_res_q      <= 1'b0;
      alu_add_q     <= 1'b0;
      op_b_imm_q    <= 1'b0;
      wb_load_q     <= 1'b0;
      mul_start_q   <= 1'b0;
      reg_we_q      <= 1'b0;
      pc_en_q       <= 1'b0;
      retire_cnt_q  <= '0;
      err_illegal_q <= 1'b0;
      err_mul_to_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      wr_res_q      <= wr_res_d;
      alu_add_q     <= alu_add_d;
      op_b_imm_q    <= op_b_imm_d;
      wb_load_q     <= wb_load_d;
      mul_start_q   <= mul_start_d;
      reg_we_q      <= reg_we_d;
      pc_en_q       <= pc_en_d;
      retire_cnt_q  <= retire_cnt_d;
      err_illegal_q <= err_illegal_d;
      err_mul_to_q  <= err_mul_to_d;
    end
  end

  assign bus.mul_start   = mul_start_q;
  assign bus.alu_add     = alu_add_q;
  assign bus.op_b_imm    = op_b_imm_q;
  assign bus.wb_load     = wb_load_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.pc_en       = pc_en_q;
  assign bus.retire_cnt  = retire_cnt_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_mul_to  = err_mul_to_q;

endmodule

// File: tb/tb_execute_sequencer.sv
// Self-checking bench for execute_sequencer: directed vector table, randomized
// instructions against a per-instruction outcome model, and reset corner cases.
module tb_execute_sequencer;

  localparam int MUL_TO = 16;
  localparam int LIMIT  = 400;

  bit   clk = 1'b0;
  logic n_reset;

  always #5 clk = ~clk;

  execute_sequencer_if #(.IMM_WIDTH(8), .RET_WIDTH(16)) bus ();
  execute_sequencer_if #(.IMM_WIDTH(8), .RET_WIDTH(4))  bus2 ();

  execute_sequencer #(.IMM_WIDTH(8), .MUL_TIMEOUT(MUL_TO), .RET_WIDTH(16)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // Narrow-counter twin sees the same instruction stream to exercise wraparound
  execute_sequencer #(.IMM_WIDTH(8), .MUL_TIMEOUT(MUL_TO), .RET_WIDTH(4)) dut_w (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus2)
  );

  assign bus2.instr_valid = bus.instr_valid;
  assign bus2.f_add       = bus.f_add;
  assign bus2.f_imm       = bus.f_imm;
  assign bus2.f_wait      = bus.f_wait;
  assign bus2.f_load      = bus.f_load;
  assign bus2.f_wr_res    = bus.f_wr_res;
  assign bus2.imm         = bus.imm;
  assign bus2.mul_done    = bus.mul_done;
  assign bus2.err_clr     = bus.err_clr;

  typedef struct {
    logic       f_add;
    logic       f_imm;
    logic       f_wait;
    logic       f_load;
    logic       f_wr_res;
    logic [7:0] imm;
    int         dly;   // cycle after accept in which mul_done pulses (0 = never)
    logic       clr;   // err_clr driven in the accept cycle
    int         lat;   // expected cycle after accept carrying pc_en
    int         we;    // expected number of reg_we cycles
    int         st;    // expected number of mul_start cycles
    logic       ill;   // expected sticky err_illegal afterwards
    logic       mto;   // expected sticky err_mul_to afterwards
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ret = 0;
  logic ill_m = 1'b0;
  logic mto_m = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of one instruction derived directly from the classification rules
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r     = v;
    r.st  = 0;
    r.we  = 0;
    r.ill = ill_m & ~v.clr;
    r.mto = mto_m & ~v.clr;
    if (v.f_wait) begin
      r.lat = (v.imm == 8'd0) ? 1 : int'(v.imm) + 1;
    end else if (v.f_load || v.f_add) begin
      r.lat = 1;
      r.we  = int'(v.f_wr_res);
    end else if (v.f_wr_res) begin
      r.st = 1;
      if (v.dly >= 1 && v.dly <= MUL_TO) begin
        r.lat = v.dly + 1;
        r.we  = 1;
      end else begin
        r.lat = MUL_TO + 1;
        r.mto = 1'b1;
      end
    end else begin
      r.lat = 1;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic run_instr(input vec_t v);
    int k, lat, n_start, start_at, n_we, n_bad;
    bit seen;
    k = 0; lat = 0; n_start = 0; start_at = 0; n_we = 0; n_bad = 0; seen = 1'b0;
    @(negedge clk);
    check("ready_before_accept", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.f_add       = v.f_add;
    bus.f_imm       = v.f_imm;
    bus.f_wait      = v.f_wait;
    bus.f_load      = v.f_load;
    bus.f_wr_res    = v.f_wr_res;
    bus.imm         = v.imm;
    bus.err_clr     = v.clr;
    @(posedge clk);
    while (!seen && k < LIMIT) begin
      @(negedge clk);
      k++;
      bus.instr_valid = 1'b0;
      bus.err_clr     = 1'b0;
      if (k == 1) check("ready_after_accept", bus.instr_ready, 0);
      if (bus.mul_start) begin
        n_start++;
        if (start_at == 0) start_at = k;
      end
      if (bus.reg_we) n_we++;
      if (bus.alu_add != v.f_add || bus.op_b_imm != v.f_imm || bus.wb_load != v.f_load)
        n_bad++;
      if (bus.pc_en) begin
        seen = 1'b1;
        lat  = k;
      end
      bus.mul_done = (k == v.dly);
    end
    bus.mul_done = 1'b0;
    if (!seen) $display("FAIL pc_en_wait: no pc_en within %0d cycles", LIMIT);
    check("pc_en_latency", lat, v.lat);
    check("reg_we_cycles", n_we, v.we);
    check("mul_start_cycles", n_start, v.st);
    if (v.st != 0) check("mul_start_position", start_at, 1);
    check("latched_flag_cycles", n_bad, 0);
    exp_ret = (exp_ret + 1) & 32'hFFFF;
    ill_m   = v.ill;
    mto_m   = v.mto;
    @(negedge clk);
    check("ready_after_retire", bus.instr_ready, 1);
    check("flags_zero_in_idle", {bus.alu_add, bus.op_b_imm, bus.wb_load, bus.reg_we, bus.pc_en}, 0);
    check("retire_cnt", bus.retire_cnt, exp_ret);
    check("retire_cnt_narrow", bus2.retire_cnt, exp_ret & 15);
    check("err_illegal", bus.err_illegal, ill_m);
    check("err_mul_to", bus.err_mul_to, mto_m);
  endtask

  task automatic reset_mid(input bit is_mul);
    int bad;
    bad = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.f_add = 1'b0; bus.f_imm = 1'b0; bus.f_load = 1'b0;
    bus.f_wait   = ~is_mul;
    bus.f_wr_res = is_mul;
    bus.imm      = 8'd20;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", bus.instr_ready, 0);
    n_reset = 1'b0;
    #1;
    check("ready_in_reset", bus.instr_ready, 1);
    check("outputs_in_reset", {bus.mul_start, bus.alu_add, bus.op_b_imm, bus.wb_load,
                               bus.reg_we, bus.pc_en, bus.err_illegal, bus.err_mul_to}, 0);
    check("retire_cnt_in_reset", bus.retire_cnt, 0);
    @(negedge clk);
    n_reset = 1'b1;
    exp_ret = 0;
    ill_m   = 1'b0;
    mto_m   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.mul_done = (i < 2);
      @(negedge clk);
      if (bus.reg_we || bus.pc_en || bus.mul_start || !bus.instr_ready) bad++;
    end
    bus.mul_done = 1'b0;
    check("quiet_after_reset", bad, 0);
    check("retire_cnt_after_reset", bus.retire_cnt, 0);
  endtask

  vec_t tbl[17];
  vec_t rv;

  initial begin
    // add imm wait load wr  imm    dly clr lat we st ill mto
    tbl[0]  = '{1, 0, 0, 0, 1, 8'd0,   0, 0,   1, 1, 0, 0, 0}; // ADD
    tbl[1]  = '{1, 1, 0, 0, 1, 8'h3c,  0, 0,   1, 1, 0, 0, 0}; // ADDI
    tbl[2]  = '{0, 0, 0, 1, 1, 8'd0,   0, 0,   1, 1, 0, 0, 0}; // LDSW
    tbl[3]  = '{0, 1, 0, 0, 1, 8'd7,   4, 0,   5, 1, 1, 0, 0}; // MULI, done 3 after start
    tbl[4]  = '{0, 0, 0, 0, 1, 8'd0,   0, 0,  17, 0, 1, 0, 1}; // MUL timeout
    tbl[5]  = '{0, 0, 1, 0, 0, 8'd5,   3, 0,   6, 0, 0, 0, 1}; // WAIT 5, stray done
    tbl[6]  = '{0, 0, 1, 0, 0, 8'd0,   0, 1,   1, 0, 0, 0, 0}; // WAIT 0 + clear
    tbl[7]  = '{0, 0, 1, 0, 0, 8'd255, 0, 0, 256, 0, 0, 0, 0}; // WAIT 255
    tbl[8]  = '{0, 0, 0, 0, 0, 8'd0,   0, 0,   1, 0, 0, 1, 0}; // illegal
    tbl[9]  = '{0, 0, 0, 0, 0, 8'd0,   0, 1,   1, 0, 0, 1, 0}; // illegal + clear: set wins
    tbl[10] = '{0, 0, 0, 0, 1, 8'd0,  16, 0,  17, 1, 1, 1, 0}; // done in timeout cycle
    tbl[11] = '{1, 0, 0, 0, 1, 8'd0,   0, 1,   1, 1, 0, 0, 0}; // ADD + clear
    tbl[12] = '{0, 0, 0, 0, 1, 8'd0,   1, 0,   2, 1, 1, 0, 0}; // MUL immediate done
    tbl[13] = '{1, 0, 1, 0, 1, 8'd2,   0, 0,   3, 0, 0, 0, 0}; // WAIT beats ADD
    tbl[14] = '{0, 0, 0, 0, 1, 8'd0,  17, 0,  17, 0, 1, 0, 1}; // done one cycle late
    tbl[15] = '{0, 0, 0, 1, 0, 8'd0,   0, 0,   1, 0, 0, 0, 1}; // load without write
    tbl[16] = '{0, 0, 1, 0, 0, 8'd1,   0, 1,   2, 0, 0, 0, 0}; // WAIT 1 + clear

    n_reset         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.f_add       = 1'b0;
    bus.f_imm       = 1'b0;
    bus.f_wait      = 1'b0;
    bus.f_load      = 1'b0;
    bus.f_wr_res    = 1'b0;
    bus.imm         = 8'd0;
    bus.mul_done    = 1'b0;
    bus.err_clr     = 1'b0;
    #3;
    check("reset_ready", bus.instr_ready, 1);
    check("reset_outputs", {bus.mul_start, bus.alu_add, bus.op_b_imm, bus.wb_load,
                            bus.reg_we, bus.pc_en, bus.err_illegal, bus.err_mul_to}, 0);
    check("reset_retire_cnt", bus.retire_cnt, 0);
    @(negedge clk);
    n_reset = 1'b1;

    foreach (tbl[i]) run_instr(tbl[i]);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int n = 0; n < 250; n++) begin
      rv.f_wait   = ($urandom_range(0, 4) == 0);
      rv.f_load   = ($urandom_range(0, 4) == 0);
      rv.f_add    = ($urandom_range(0, 2) == 0);
      rv.f_wr_res = ($urandom_range(0, 1) == 1);
      rv.f_imm    = ($urandom_range(0, 1) == 1);
      if (!(rv.f_wait || rv.f_load || rv.f_add || rv.f_wr_res)) rv.f_imm = 1'b0;
      rv.imm = 8'($urandom_range(0, 12));
      rv.dly = $urandom_range(0, 20);
      rv.clr = ($urandom_range(0, 5) == 0);
      rv = model(rv);
      run_instr(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execute_sequencer.md
# execute_sequencer

Multi-cycle execute controller for the CPU core. It accepts one decoded instruction at a time from fetch over a valid/ready handshake and runs it through the matching state sequence: single-cycle ALU ops, handshaked multiply, programmable WAIT stall, or switch load. It drives the datapath select lines, register-file write enable and PC advance. It sits between the instruction decoder flag outputs and the ALU/multiplier/register file.

## Interface
- IMM_WIDTH, 8, width of immediate field; WAIT uses it as stall cycle count
- MUL_TIMEOUT, 16, max cycles in MUL before abort; must be ≥ 2
- RET_WIDTH, 16, width of retired-instruction counter
- clk  in  1  clock, rising edge
- n_reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch presents a decoded instruction
- instr_ready  out  1  sequencer can accept; high only in IDLE
- f_add, f_imm, f_wait, f_load, f_wr_res  in  1 each  decoder flags, sampled on accept
- imm  in  IMM_WIDTH  immediate, sampled on accept
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_done  in  1  multiplier result valid
- alu_add  out  1  latched f_add (ALU add vs multiply path)
- op_b_imm  out  1  latched f_imm (operand B from immediate)
- wb_load  out  1  latched f_load (writeback from switches)
- reg_we  out  1  register-file write strobe
- pc_en  out  1  PC advance / retire strobe
- retire_cnt  out  RET_WIDTH  count of retired instructions
- err_illegal  out  1  sticky: all-zero flag set accepted
- err_mul_to  out  1  sticky: multiply timed out
- err_clr  in  1  synchronous clear of both sticky errors

## Operation
- States: IDLE, MUL, WAIT, WB, RETIRE.
- IDLE: instr_ready=1. Accept = instr_valid & instr_ready at clock edge. On accept, latch flags and imm, then classify in priority order:
  - f_wait → WAIT with counter=imm, or RETIRE if imm==0.
  - f_load or f_add → WB.
  - f_wr_res alone (multiply) → MUL, with mul_start=1 in the first MUL cycle and MUL timer=1.
  - no flags → RETIRE and set err_illegal.
- MUL: hold until mul_done. If mul_done=1 → WB; this check takes priority over timeout. Otherwise, when timer==MUL_TIMEOUT → RETIRE and set err_mul_to (no register write); else timer+1. mul_done outside MUL is ignored.
- WAIT: counter decrements each cycle. When counter==1 → RETIRE. Total WAIT residency is exactly imm cycles.
- WB: reg_we=latched f_wr_res, pc_en=1 → IDLE.
- RETIRE: pc_en=1, reg_we=0 → IDLE.
- retire_cnt increments by 1 on every pc_en cycle and wraps modulo 2^RET_WIDTH.
- alu_add, op_b_imm and wb_load equal the latched flags from the cycle after accept until return to IDLE; they are 0 in IDLE.
- err_clr and an error set in the same cycle: set wins.
- Reset (asynchronous, any state): state=IDLE; all latches, counters and retire_cnt go to 0; err flags go to 0. During reset all outputs are 0 except instr_ready=1. Any in-flight instruction is dropped with no write and no pc_en.

## Timing
- All outputs except instr_ready are registered (Moore). instr_ready is decoded from the state.
- ADD/ADDI/LDSW: accept at edge T. WB in cycle T+1 with reg_we=pc_en=1. IDLE in T+2. Max throughput is 1 instruction per 2 cycles.
- MUL: accept at T. mul_start in T+1. If mul_done is seen in cycle T+k, WB is in T+k+1. Timeout with no done: RETIRE in T+MUL_TIMEOUT+1.
- WAIT imm=N≥1: WAIT in cycles T+1..T+N, RETIRE in T+N+1. imm=0: RETIRE in T+1.
- instr_valid with no accept (not IDLE): fetch must hold the instruction; the sequencer does not sample it.

## Test plan
- Reset then ADD (f_add=f_wr_res=1) at T → instr_ready=0 at T+1, reg_we=pc_en=alu_add=1 in T+1, instr_ready=1 at T+2, retire_cnt=1.
- MULI with mul_done raised 3 cycles after mul_start → mul_start is a single pulse; WB one cycle after mul_done; op_b_imm=1, alu_add=0 throughout.
- MUL with mul_done never asserted, MUL_TIMEOUT=16 → RETIRE at T+17, reg_we never high, err_mul_to=1; err_clr → 0 next cycle.
- WAIT imm=5 → pc_en exactly at T+6 and reg_we=0. WAIT imm=0 → pc_en at T+1. WAIT imm=255 → pc_en at T+256.
- All-zero flags accepted → pc_en at T+1, err_illegal=1 and stays high until err_clr; err_clr asserted in the same cycle as a new illegal keeps it 1.
- n_reset pulsed mid-MUL and mid-WAIT → immediate IDLE, instr_ready=1, no reg_we/pc_en; late mul_done afterwards is ignored. Back-to-back 2^16 retirements → retire_cnt wraps to 0.
